// File: rtl/cache_controller_pkg.sv
// Shared types for the CPU-side MESI cache controller.
//   mesi_t     : line coherence state, I=00 S=01 E=10 M=11
//   cc_state_t : controller FSM states
//   helpers    : MESI predicates used by the lookup decode
package cache_controller_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_t;

  typedef enum logic [2:0] {
    CC_IDLE,
    CC_LOOKUP,
    CC_WB,
    CC_REFILL,
    CC_UPGRADE
  } cc_state_t;

  function automatic logic mesi_valid(mesi_t s);
    return s != MESI_I;
  endfunction

  function automatic logic mesi_dirty(mesi_t s);
    return s == MESI_M;
  endfunction

  // E and M lines are owned exclusively, so a store can complete locally.
  function automatic logic mesi_writable(mesi_t s);
    return (s == MESI_E) || (s == MESI_M);
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Bundle of CPU request/response, datapath lookup/array-write and ACE
// request/completion signals around the cache controller.
//   master : environment side (CPU, datapath, ACE controller)
//   slave  : the cache controller
interface cache_controller_if;
  logic       cpu_req_valid;
  logic       cpu_req_we;
  logic       cpu_req_ready;
  logic       cpu_resp_valid;
  logic       cpu_resp_err;
  logic       hit;
  logic [1:0] line_state;
  logic       ace_resp_shared;
  logic       ace_ready;
  logic       read_req;
  logic       write_req;
  logic       invalid_req;
  logic       addr_we;
  logic       tag_we;
  logic       state_we;
  logic [1:0] new_state;
  logic       data_we;
  logic       data_sel;

  modport master (
    output cpu_req_valid, cpu_req_we, hit, line_state, ace_resp_shared, ace_ready,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_err, read_req, write_req,
           invalid_req, addr_we, tag_we, state_we, new_state, data_we, data_sel
  );

  modport slave (
    input  cpu_req_valid, cpu_req_we, hit, line_state, ace_resp_shared, ace_ready,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_err, read_req, write_req,
           invalid_req, addr_we, tag_we, state_we, new_state, data_we, data_sel
  );
endinterface

// File: rtl/cache_controller_ace_wait_timer.sv
// Counts cycles spent waiting for ace_ready.
//   clk, rst_n : clock, async active-low reset
//   clear      : restart count at 0 (has priority over enable)
//   enable     : count one wait cycle
//   expire     : count has reached ACE_TIMEOUT-1 (last allowed wait cycle)
// The count saturates at ACE_TIMEOUT-1 so it can never wrap back to a
// non-expired value.
module cache_controller_ace_wait_timer #(
  parameter int ACE_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = $clog2(ACE_TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(ACE_TIMEOUT - 1);

  logic [TW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != LAST)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expire = (count_q == LAST);

endmodule

// File: rtl/cache_controller.sv
// CPU-side MESI cache controller. Accepts one CPU load/store at a time,
// evaluates hit/line state from the datapath, issues single-cycle
// ReadShared / WriteClean / MakeUnique requests to the ACE controller,
// then updates tag/state/data arrays and answers the CPU.
//   clk, rst_n : clock, async active-low reset
//   bus        : cache_controller_if.slave (CPU, datapath, ACE signals)
// A wait for ace_ready longer than ACE_TIMEOUT cycles aborts the request
// with cpu_resp_err and no array update.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int ACE_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cache_controller_if.slave    bus
);

  cc_state_t state_q, state_d;
  logic      we_q;
  mesi_t     line_mesi;
  logic      line_hit;
  logic      timer_clear, timer_enable, timer_expire;

  logic  req_ready, resp_valid, resp_err;
  logic  rd_req, wr_req, inv_req;
  logic  a_we, t_we, s_we, d_we, d_sel;
  mesi_t n_state;

  assign line_mesi = mesi_t'(bus.line_state);
  // A tag match on an invalid line is a miss.
  assign line_hit  = bus.hit && mesi_valid(line_mesi);

  cache_controller_ace_wait_timer #(.ACE_TIMEOUT(ACE_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CC_IDLE;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == CC_IDLE && bus.cpu_req_valid) we_q <= bus.cpu_req_we;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    rd_req     = 1'b0;
    wr_req     = 1'b0;
    inv_req    = 1'b0;
    a_we       = 1'b0;
    t_we       = 1'b0;
    s_we       = 1'b0;
    d_we       = 1'b0;
    d_sel      = 1'b0;
    n_state    = MESI_I;
    unique case (state_q)
      CC_IDLE: begin
        req_ready = 1'b1;
        if (bus.cpu_req_valid) begin
          a_we    = 1'b1;
          state_d = CC_LOOKUP;
        end
      end
      CC_LOOKUP: begin
        if (line_hit && !we_q) begin
          resp_valid = 1'b1;
          state_d    = CC_IDLE;
        end else if (line_hit && mesi_writable(line_mesi)) begin
          d_we       = 1'b1;
          s_we       = 1'b1;
          n_state    = MESI_M;
          resp_valid = 1'b1;
          state_d    = CC_IDLE;
        end else if (line_hit) begin
          inv_req = 1'b1;
          state_d = CC_UPGRADE;
        end else if (mesi_dirty(line_mesi)) begin
          wr_req  = 1'b1;
          state_d = CC_WB;
        end else begin
          rd_req  = 1'b1;
          state_d = CC_REFILL;
        end
      end
      CC_WB, CC_REFILL, CC_UPGRADE: begin
        // ace_ready on the expiry cycle still counts as a normal completion.
        if (bus.ace_ready) begin
          if (state_q == CC_WB) begin
            rd_req  = 1'b1;
            state_d = CC_REFILL;
          end else if (state_q == CC_REFILL) begin
            t_we    = 1'b1;
            d_we    = 1'b1;
            d_sel   = 1'b1;
            s_we    = 1'b1;
            n_state = bus.ace_resp_shared ? MESI_S : MESI_E;
            // Re-run the lookup so a store can take the E or S path.
            state_d = CC_LOOKUP;
          end else begin
            d_we       = 1'b1;
            s_we       = 1'b1;
            n_state    = MESI_M;
            resp_valid = 1'b1;
            state_d    = CC_IDLE;
          end
        end else if (timer_expire) begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
          state_d    = CC_IDLE;
        end
      end
      default: state_d = CC_IDLE;
    endcase
  end

  assign timer_enable = (state_q == CC_WB) || (state_q == CC_REFILL) || (state_q == CC_UPGRADE);
  assign timer_clear  = (state_d != state_q);

  assign bus.cpu_req_ready  = req_ready;
  assign bus.cpu_resp_valid = resp_valid;
  assign bus.cpu_resp_err   = resp_err;
  assign bus.read_req       = rd_req;
  assign bus.write_req      = wr_req;
  assign bus.invalid_req    = inv_req;
  assign bus.addr_we        = a_we;
  assign bus.tag_we         = t_we;
  assign bus.state_we       = s_we;
  assign bus.new_state      = n_state;
  assign bus.data_we        = d_we;
  assign bus.data_sel       = d_sel;

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;
  localparam int TO = 8;

  typedef struct packed {
    logic       rdy, resp, err, rd, wr, inv, awe, twe, swe;
    logic [1:0] ns;
    logic       dwe, dsel;
  } obs_t;

  typedef struct {
    int    cyc;
    obs_t  o;
    string name;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_pass = 0;
  exp_t  q[$];

  cache_controller_if bus();

  cache_controller #(.ACE_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t sample();
    obs_t o;
    o.rdy  = bus.cpu_req_ready;
    o.resp = bus.cpu_resp_valid;
    o.err  = bus.cpu_resp_err;
    o.rd   = bus.read_req;
    o.wr   = bus.write_req;
    o.inv  = bus.invalid_req;
    o.awe  = bus.addr_we;
    o.twe  = bus.tag_we;
    o.swe  = bus.state_we;
    o.ns   = bus.new_state;
    o.dwe  = bus.data_we;
    o.dsel = bus.data_sel;
    return o;
  endfunction

  task automatic check_obs(string name, obs_t got, obs_t exp, bit strict);
    obs_t m;
    m = '1;
    if (!strict) begin
      if (!exp.swe) m.ns = 2'b00;
      if (!exp.dwe) m.dsel = 1'b0;
    end
    n_checks++;
    if ((got & m) == (exp & m)) n_pass++;
    else $display("FAIL %s @cyc %0d: got %b required %b (rdy,resp,err,rd,wr,inv,awe,twe,swe,ns,dwe,dsel)",
                  name, cyc, got, exp);
  endtask

  task automatic fail_chk(string name, string detail);
    n_checks++;
    $display("FAIL %s @cyc %0d: %s", name, cyc, detail);
  endtask

  // Monitor: every cycle with any activity output is one scoreboard event.
  always @(negedge clk) begin
    obs_t o;
    exp_t e;
    if (rst_n) begin
      o = sample();
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        fail_chk({"missing_", e.name}, $sformatf("got no output event, required one at cycle %0d", e.cyc));
      end
      if (o.resp | o.rd | o.wr | o.inv | o.awe | o.twe | o.swe | o.dwe) begin
        if (q.size() == 0 || q[0].cyc != cyc)
          fail_chk("unexpected_event", $sformatf("got outputs %b, required no event", o));
        else begin
          e = q.pop_front();
          check_obs(e.name, o, e.o, 1'b0);
        end
      end
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic push(string name, obs_t o);
    exp_t e;
    e.cyc  = cyc;
    e.o    = o;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic noise(bit allow_valid, bit allow_ready);
    bus.cpu_req_valid   = allow_valid ? 1'($urandom_range(0, 1)) : 1'b0;
    bus.cpu_req_we      = 1'($urandom_range(0, 1));
    bus.hit             = 1'($urandom_range(0, 1));
    bus.line_state      = 2'($urandom_range(0, 3));
    bus.ace_resp_shared = 1'($urandom_range(0, 1));
    bus.ace_ready       = allow_ready ? ($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  // Reference behaviour of one CPU request. lat: cycles from request pulse
  // to ace_ready for the 1st/2nd/3rd ACE transaction (> TO = never answered).
  task automatic run_txn(input bit we, input bit hit_i, input logic [1:0] ls_i,
                         input int l0, input int l1, input int l2, input bit sh);
    obs_t       e;
    int         lats[3];
    int         k, kind, w;
    bit         done, waiting, got;
    bit         cur_hit;
    logic [1:0] cur_ls;
    lats[0] = l0; lats[1] = l1; lats[2] = l2;
    noise(1'b0, 1'b1);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_we    = we;
    e = '0; e.rdy = 1'b1; e.awe = 1'b1;
    push("accept", e);
    adv();
    cur_hit = hit_i; cur_ls = ls_i; k = 0; done = 1'b0; kind = 0;
    while (!done) begin
      noise(1'b1, 1'b1);
      bus.hit = cur_hit; bus.line_state = cur_ls;
      e = '0;
      waiting = 1'b1;
      if (cur_hit && cur_ls != 2'b00) begin
        if (!we) begin
          e.resp = 1'b1; push("load_hit", e); done = 1'b1; waiting = 1'b0;
        end else if (cur_ls >= 2'b10) begin
          e.dwe = 1'b1; e.swe = 1'b1; e.ns = 2'b11; e.resp = 1'b1;
          push("store_hit", e); done = 1'b1; waiting = 1'b0;
        end else begin
          e.inv = 1'b1; push("upgrade_req", e); kind = 2;
        end
      end else if (cur_ls == 2'b11) begin
        e.wr = 1'b1; push("writeback_req", e); kind = 0;
      end else begin
        e.rd = 1'b1; push("refill_req", e); kind = 1;
      end
      adv();
      while (waiting) begin
        w = 1; got = 1'b0;
        while (1) begin
          noise(1'b1, 1'b0);
          if (w == lats[k]) begin
            bus.ace_ready = 1'b1;
            bus.ace_resp_shared = sh;
            got = 1'b1;
          end
          if (got || w == TO) break;
          adv();
          w++;
        end
        k++;
        e = '0;
        waiting = 1'b0;
        if (!got) begin
          e.resp = 1'b1; e.err = 1'b1; push("timeout", e); done = 1'b1;
        end else if (kind == 0) begin
          e.rd = 1'b1; push("wb_done_refill_req", e); kind = 1; waiting = 1'b1;
        end else if (kind == 1) begin
          e.twe = 1'b1; e.dwe = 1'b1; e.dsel = 1'b1; e.swe = 1'b1;
          e.ns = sh ? 2'b01 : 2'b10;
          push("refill_done", e);
          cur_hit = 1'b1; cur_ls = e.ns;
        end else begin
          e.dwe = 1'b1; e.swe = 1'b1; e.ns = 2'b11; e.resp = 1'b1;
          push("upgrade_done", e); done = 1'b1;
        end
        adv();
      end
    end
    repeat ($urandom_range(0, 2)) begin
      noise(1'b0, 1'b1);
      adv();
    end
  endtask

  function automatic int rand_lat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 5) return int'($urandom_range(1, 3));
    if (r == 6) return TO;
    if (r == 7) return TO - 1;
    return TO + 1;
  endfunction

  initial begin
    obs_t idle_o;
    idle_o = '0; idle_o.rdy = 1'b1;
    noise(1'b0, 1'b0);
    #2;
    check_obs("reset_outputs", sample(), idle_o, 1'b1);
    @(posedge clk); #3 rst_n = 1'b1;
    adv();

    run_txn(1'b0, 1'b1, 2'b10, 1, 1, 1, 1'b0);          // load hit E
    run_txn(1'b1, 1'b1, 2'b01, 3, 1, 1, 1'b0);          // store hit S, ready 3 later
    run_txn(1'b0, 1'b0, 2'b11, 4, 4, 1, 1'b1);          // load miss, dirty victim
    run_txn(1'b1, 1'b0, 2'b00, 2, 1, 1, 1'b0);          // store miss, refill E
    run_txn(1'b1, 1'b0, 2'b10, 2, 3, 1, 1'b1);          // store miss, refill S, upgrade
    run_txn(1'b1, 1'b0, 2'b11, 1, 2, 3, 1'b1);          // three ACE transactions
    run_txn(1'b1, 1'b1, 2'b01, TO + 1, 1, 1, 1'b0);     // timeout
    run_txn(1'b1, 1'b1, 2'b01, TO, 1, 1, 1'b0);         // ready on expiry cycle
    run_txn(1'b0, 1'b0, 2'b11, 2, TO + 1, 1, 1'b0);     // timeout during refill
    run_txn(1'b0, 1'b1, 2'b00, 1, 1, 1, 1'b0);          // hit on invalid line = miss

    for (int i = 0; i < 250; i++)
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              rand_lat(), rand_lat(), rand_lat(), 1'($urandom_range(0, 1)));

    // Reset while waiting for a refill.
    begin
      obs_t e;
      noise(1'b0, 1'b0);
      bus.cpu_req_valid = 1'b1; bus.cpu_req_we = 1'b0;
      e = '0; e.rdy = 1'b1; e.awe = 1'b1; push("rst_accept", e);
      adv();
      noise(1'b1, 1'b0);
      bus.hit = 1'b0; bus.line_state = 2'b00;
      e = '0; e.rd = 1'b1; push("rst_refill_req", e);
      adv();
      noise(1'b1, 1'b0);
      adv();
      noise(1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1 check_obs("reset_mid_refill", sample(), idle_o, 1'b1);
      @(posedge clk); #3 rst_n = 1'b1;
      adv();
      noise(1'b0, 1'b0);
      bus.ace_ready = 1'b1; bus.ace_resp_shared = 1'b1;
      adv();
      noise(1'b0, 1'b0);
      check_obs("stray_ready_ignored", sample(), idle_o, 1'b1);
      adv();
      run_txn(1'b1, 1'b1, 2'b11, 1, 1, 1, 1'b0);
      run_txn(1'b1, 1'b1, 2'b01, TO + 1, 1, 1, 1'b0);
    end

    noise(1'b0, 1'b0);
    repeat (4) adv();
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected events, required 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required completion before time limit");
    $fatal(1, "watchdog");
  end

endmodule
